// File: rtl/alarm_ringer_pkg.sv
// Shared types and helpers for the alarm ringer: FSM state encoding and
// millisecond-to-clock-cycle conversion used to size every timer.
package alarm_ringer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RING  = 2'd1,
    ACKED = 2'd2
  } ring_state_t;

  // Product is formed in 64 bits so long holds at fast clocks cannot overflow;
  // a zero result is clamped to one cycle so terminal counts stay meaningful.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    logic [63:0] prod;
    prod = (64'(clk_hz) * 64'(ms)) / 64'd1000;
    return (prod == 64'd0) ? 1 : prod[31:0];
  endfunction

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit <= 1) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stable-time debouncer and a
// one-cycle press pulse on each debounced 0->1 transition.
module btn_debounce
  import alarm_ringer_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned DEB_MS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned DEB_CYC = ms_to_cycles(CLK_HZ, DEB_MS);
  localparam int unsigned DEB_W   = cnt_width(DEB_CYC);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

  logic [1:0]       sync_q;
  logic             stable_q;
  logic [DEB_W-1:0] deb_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchronizer chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      deb_cnt  <= '0;
      press    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn};
      press  <= 1'b0;
      // Any sample matching the accepted level restarts the stability window.
      if (sync_q[1] == stable_q) begin
        deb_cnt <= '0;
      end else if (deb_cnt >= DEB_LAST) begin
        deb_cnt  <= '0;
        stable_q <= sync_q[1];
        press    <= sync_q[1];
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alarm_ringer.sv
// Alarm ringer: IDLE/RING/ACKED controller driving a gated piezo tone, a ring
// LED and a held dismiss level. Option: ALARM_RINGER_ESCALATE_EN forces a
// continuous tone after 10 s in RING.
module alarm_ringer
  import alarm_ringer_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned TONE_HZ     = 2000,
  parameter int unsigned DEB_MS      = 20,
  parameter int unsigned BEEP_MS     = 250,
  parameter int unsigned OFF_HOLD_MS = 2000
) (
  input  logic clk,
  input  logic rst,
  input  logic alarming,
  input  logic btn_off,
  output logic off,
  output logic buzzer,
  output logic ringing
);

  localparam int unsigned BEEP_CYC = ms_to_cycles(CLK_HZ, BEEP_MS);
  localparam int unsigned HOLD_CYC = ms_to_cycles(CLK_HZ, OFF_HOLD_MS);
  localparam int unsigned HALF_RAW = CLK_HZ / (2 * TONE_HZ);
  localparam int unsigned HALF_CYC = (HALF_RAW == 0) ? 1 : HALF_RAW;

  localparam int unsigned BEEP_W = cnt_width(BEEP_CYC);
  localparam int unsigned HOLD_W = cnt_width(HOLD_CYC);
  localparam int unsigned HALF_W = cnt_width(HALF_CYC);

  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_CYC - 1);

  logic              alarm_meta;
  logic              alarm_s;
  logic              press;
  ring_state_t       state;
  ring_state_t       state_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic [BEEP_W-1:0] beep_cnt;
  logic [BEEP_W-1:0] beep_next;
  logic              gate_on;
  logic              gate_next;
  logic [HALF_W-1:0] tone_cnt;
  logic [HALF_W-1:0] tone_next;
  logic              buzz_next;
  logic              esc_force;

  btn_debounce #(
    .CLK_HZ (CLK_HZ),
    .DEB_MS (DEB_MS)
  ) u_btn_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_off),
    .press (press)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alarm_meta <= 1'b0;
      alarm_s    <= 1'b0;
    end else begin
      alarm_meta <= alarming;
      alarm_s    <= alarm_meta;
    end
  end

`ifdef ALARM_RINGER_ESCALATE_EN
  localparam int unsigned ESC_CYC = 10 * CLK_HZ;
  localparam int unsigned ESC_W   = cnt_width(ESC_CYC);
  localparam logic [ESC_W-1:0] ESC_LAST = ESC_W'(ESC_CYC - 1);

  logic [ESC_W-1:0] esc_cnt;
  logic             escalated;

  // The flag latches for the rest of this RING visit; the counter parks at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      esc_cnt   <= '0;
      escalated <= 1'b0;
    end else if (state == RING && state_next == RING) begin
      if (!escalated) begin
        if (esc_cnt >= ESC_LAST) begin
          esc_cnt   <= '0;
          escalated <= 1'b1;
        end else begin
          esc_cnt <= esc_cnt + 1'b1;
        end
      end
    end else begin
      esc_cnt   <= '0;
      escalated <= 1'b0;
    end
  end

  assign esc_force = escalated;
`else
  assign esc_force = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    hold_next  = '0;
    beep_next  = '0;
    gate_next  = 1'b0;
    tone_next  = '0;
    buzz_next  = 1'b0;

    unique case (state)
      IDLE:    if (alarm_s) state_next = RING;
      // A press wins over a simultaneous alarm drop.
      RING:    if (press) state_next = ACKED;
               else if (!alarm_s) state_next = IDLE;
      ACKED:   if (hold_cnt >= HOLD_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (state == ACKED && state_next == ACKED) begin
      hold_next = hold_cnt + 1'b1;
    end

    // Beep gate restarts "on" with a fresh phase on every RING entry.
    if (state != RING && state_next == RING) begin
      gate_next = 1'b1;
    end else if (state == RING && state_next == RING) begin
      if (beep_cnt >= BEEP_LAST) begin
        gate_next = ~gate_on | esc_force;
      end else begin
        beep_next = beep_cnt + 1'b1;
        gate_next = gate_on | esc_force;
      end
    end

    // Tone restarts high whenever the gated tone turns on.
    if (state_next == RING && gate_next) begin
      if (!(state == RING && gate_on)) begin
        buzz_next = 1'b1;
      end else if (tone_cnt >= HALF_LAST) begin
        buzz_next = ~buzzer;
      end else begin
        tone_next = tone_cnt + 1'b1;
        buzz_next = buzzer;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
      beep_cnt <= '0;
      gate_on  <= 1'b0;
      tone_cnt <= '0;
      buzzer   <= 1'b0;
      off      <= 1'b0;
      ringing  <= 1'b0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
      beep_cnt <= beep_next;
      gate_on  <= gate_next;
      tone_cnt <= tone_next;
      buzzer   <= buzz_next;
      off      <= (state_next == ACKED);
      ringing  <= (state_next == RING);
    end
  end

endmodule

// File: tb/tb_alarm_ringer.sv
// Directed self-checking bench for alarm_ringer using small timing parameters
// (1 kHz clock: tone half-period 5, beep phase 50, debounce 5, hold 200).
`timescale 1ns/1ps
module tb_alarm_ringer;

  localparam int unsigned CLK_HZ      = 1000;
  localparam int unsigned TONE_HZ     = 100;
  localparam int unsigned DEB_MS      = 5;
  localparam int unsigned BEEP_MS     = 50;
  localparam int unsigned OFF_HOLD_MS = 200;

  logic clk = 1'b0;
  logic rst;
  logic alarming;
  logic btn_off;
  logic off;
  logic buzzer;
  logic ringing;

  int vectors     = 0;
  int miscompares = 0;

  alarm_ringer #(
    .CLK_HZ      (CLK_HZ),
    .TONE_HZ     (TONE_HZ),
    .DEB_MS      (DEB_MS),
    .BEEP_MS     (BEEP_MS),
    .OFF_HOLD_MS (OFF_HOLD_MS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .alarming (alarming),
    .btn_off  (btn_off),
    .off      (off),
    .buzzer   (buzzer),
    .ringing  (ringing)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected buzzer k cycles after RING entry: 5-cycle half-periods starting
  // high, gated 50 on / 50 off; with escalation, continuous from k=10000.
  function automatic logic exp_buzz(input int k);
    logic tone;
    tone = ((k / 5) % 2) == 0;
`ifdef ALARM_RINGER_ESCALATE_EN
    if (k >= 10000) return tone;
`endif
    return (((k / 50) % 2) == 0) && tone;
  endfunction

  initial begin
    logic        any_out;
    logic        prev_off;
    logic        buzz_acked;
    logic        ring_acked;
    logic [13:0] bounce;
    int          first_off;
    int          last_off;
    int          off_rises;

    rst      = 1'b1;
    alarming = 1'b0;
    btn_off  = 1'b0;
    step(3);
    check("reset_off", off, 0);
    check("reset_buzzer", buzzer, 0);
    check("reset_ringing", ringing, 0);
    rst = 1'b0;
    step(2);

    // Press while idle must not move the FSM or raise off.
    any_out = 1'b0;
    for (int i = 0; i < 24; i++) begin
      btn_off = (i < 12);
      step(1);
      any_out = any_out | off | ringing;
    end
    check("idle_press_no_effect", any_out, 0);

    // Alarm rises: RING on the third edge, then the gated tone pattern.
    alarming = 1'b1;
    step(2);
    check("ring_latency_2", ringing, 0);
    step(1);
    check("ring_latency_3", ringing, 1);
    for (int k = 0; k < 150; k++) begin
      check($sformatf("beep_k%0d", k), buzzer, exp_buzz(k));
      step(1);
    end

    // Bouncing press during RING: one acknowledge, 200 cycles of off.
    bounce     = 14'b11_1111_1111_0101;
    first_off  = -1;
    last_off   = -1;
    off_rises  = 0;
    prev_off   = 1'b0;
    buzz_acked = 1'b0;
    ring_acked = 1'b0;
    for (int s = 0; s <= 230; s++) begin
      if (off) begin
        if (first_off < 0) first_off = s;
        last_off = s;
        if (!prev_off) off_rises++;
        buzz_acked = buzz_acked | buzzer;
        ring_acked = ring_acked | ringing;
      end
      prev_off = off;
      if (s == 11) check("pre_ack_ringing", ringing, 1);
      btn_off = (s < 14) ? bounce[s] : 1'b0;
      if (s == 20) alarming = 1'b0;
      step(1);
    end
    check("ack_first_off", first_off, 12);
    check("ack_last_off", last_off, 211);
    check("ack_single_press", off_rises, 1);
    check("ack_buzzer_quiet", buzz_acked, 0);
    check("ack_ringing_low", ring_acked, 0);
    check("post_hold_off", off, 0);
    check("post_hold_ringing", ringing, 0);
    check("post_hold_buzzer", buzzer, 0);

    // Alarm drops during RING with no press.
    alarming = 1'b1;
    step(3);
    check("ring2_entry", ringing, 1);
    any_out = 1'b0;
    for (int i = 0; i < 20; i++) begin
      any_out = any_out | off;
      step(1);
    end
    alarming = 1'b0;
    step(2);
    any_out = any_out | off;
    check("drop_latency_2", ringing, 1);
    step(1);
    any_out = any_out | off;
    check("drop_ringing", ringing, 0);
    check("drop_buzzer", buzzer, 0);
    check("drop_off_never", any_out, 0);

    // Reset asserted mid-ACKED, alarm still high.
    alarming = 1'b1;
    step(3);
    check("ring3_entry", ringing, 1);
    btn_off = 1'b1;
    step(10);
    btn_off = 1'b0;
    check("ack3_off", off, 1);
    step(50);
    rst = 1'b1;
    #1;
    check("async_rst_off", off, 0);
    check("async_rst_ringing", ringing, 0);
    check("async_rst_buzzer", buzzer, 0);
    @(negedge clk);
    rst = 1'b0;
    step(2);
    check("rerun_latency_2", ringing, 0);
    step(1);
    check("rerun_latency_3", ringing, 1);

    // Long RING: gating persists, or continuous tone with escalation.
    step(10000);
    for (int k = 10000; k < 10200; k++) begin
      check($sformatf("long_k%0d", k), buzzer, exp_buzz(k));
      step(1);
    end
    check("long_ringing", ringing, 1);

    alarming = 1'b0;
    step(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alarm_ringer.md
ALARM_RINGER -- requirements
Module: alarm_ringer

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter TONE_HZ, default 2000, buzzer square-wave frequency.
REQ-003 Parameter DEB_MS, default 20, button debounce stable time in ms.
REQ-004 Parameter BEEP_MS, default 250, beep on-time and off-time in ms.
REQ-005 Parameter OFF_HOLD_MS, default 2000, duration the off level is held after acknowledge.
REQ-006 clk  in  1  single system clock; all logic on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 alarming  in  1  alarm-active level from the alarm window block (sec_clk domain, asynchronous to clk).
REQ-009 btn_off  in  1  raw, bouncing, active-high dismiss button.
REQ-010 off  out  1  dismiss level back to the alarm window block.
REQ-011 buzzer  out  1  gated square wave to the piezo.
REQ-012 ringing  out  1  high while in RING (LED indicator).

Function
REQ-013 alarming SHALL pass a 2-flop synchronizer before use; alarm_s denotes the synchronized value.
REQ-014 btn_off SHALL pass a 2-flop synchronizer and debouncer; output changes only after input stable DEB_MS*CLK_HZ/1000 consecutive cycles; a single-cycle press pulse SHALL be generated on its 0->1 transition.
REQ-015 FSM states IDLE, RING, ACKED.
REQ-016 IDLE->RING on alarm_s=1; press pulses in IDLE are ignored.
REQ-017 RING->ACKED on press pulse; RING->IDLE on alarm_s=0 with no press; press and alarm_s fall in the same cycle -> ACKED.
REQ-018 ACKED->IDLE when hold counter reaches OFF_HOLD_MS*CLK_HZ/1000 cycles; alarm_s ignored in ACKED.
REQ-019 off SHALL be 1 exactly in ACKED (registered, asserted the cycle after the press pulse); hold guarantees capture by a 1 Hz sampler.
REQ-020 ringing SHALL be 1 exactly in RING.
REQ-021 Beep gate: in RING a phase counter alternates on/off every BEEP_MS*CLK_HZ/1000 cycles, starting "on" at RING entry; counter cleared on every RING entry.
REQ-022 Tone: while gate on, buzzer toggles every CLK_HZ/(2*TONE_HZ) cycles starting at 1; while gate off or outside RING, buzzer=0 and tone counter cleared.
REQ-023 All counters SHALL be sized by $clog2 of their terminal count and never wrap; terminal compare is ">= limit-1" then clear.

Reset
REQ-024 On rst: state=IDLE, off=0, buzzer=0, ringing=0, all counters and synchronizer/debounce flops 0.
REQ-025 rst mid-RING or mid-ACKED SHALL drop all outputs asynchronously; after release, a still-high alarm_s re-enters RING after synchronizer latency.

Configuration
REQ-026 Macro ALARM_RINGER_ESCALATE_EN: when defined, after 10 s continuous in RING (10*CLK_HZ cycles) the beep gate is forced permanently on (continuous tone) until RING exit; when undefined, the on/off pattern continues indefinitely and the escalation counter is absent.

Structure
REQ-027 Package alarm_ringer_pkg SHALL hold the state enum (IDLE, RING, ACKED) and the ms-to-cycles conversion function.
REQ-028 Sub-module btn_debounce (sync + debounce + rise pulse, parameters CLK_HZ, DEB_MS) SHALL be instantiated once.

Verification (bench params CLK_HZ=1000, TONE_HZ=100, DEB_MS=5, BEEP_MS=50, OFF_HOLD_MS=200)
REQ-029 alarming 0->1 -> ringing=1 within 3 cycles; buzzer toggles every 5 cycles for 50 cycles, then 0 for 50 cycles, repeating.
REQ-030 btn_off bounces 3 times in 4 cycles then held high 10 cycles during RING -> exactly one press; off=1 for 200 cycles, then IDLE, off=0, buzzer=0.
REQ-031 alarming drops during RING with no press -> IDLE within 3 cycles, buzzer=0, off never asserted.
REQ-032 rst asserted during ACKED -> off=0 immediately (same time step, no clock edge); with alarming still high, ringing=1 again within 3 cycles of release.
REQ-033 With ALARM_RINGER_ESCALATE_EN, hold RING 10000 cycles -> buzzer toggles every 5 cycles with no off-gaps; without macro, 50/50 gating persists.
REQ-034 Press in IDLE (alarming=0) -> no state change, off stays 0.
